// File: rtl/flag_branch_unit_pkg.sv
// Shared types and constants for the flag/branch resolution slice.
package flag_branch_unit_pkg;

   // Condition-code field width used by decode and branch resolution.
   localparam int unsigned COND_W = 4;

   localparam logic [COND_W-1:0] COND_EQ     = 4'd0;
   localparam logic [COND_W-1:0] COND_NE     = 4'd1;
   localparam logic [COND_W-1:0] COND_LT     = 4'd2;
   localparam logic [COND_W-1:0] COND_GE     = 4'd3;
   localparam logic [COND_W-1:0] COND_GT     = 4'd4;
   localparam logic [COND_W-1:0] COND_LE     = 4'd5;
   localparam logic [COND_W-1:0] COND_LTU    = 4'd6;
   localparam logic [COND_W-1:0] COND_GEU    = 4'd7;
   localparam logic [COND_W-1:0] COND_NEG    = 4'd8;
   localparam logic [COND_W-1:0] COND_POS    = 4'd9;
   localparam logic [COND_W-1:0] COND_OV     = 4'd10;
   localparam logic [COND_W-1:0] COND_NOV    = 4'd11;
   localparam logic [COND_W-1:0] COND_ALWAYS = 4'd12;
   localparam logic [COND_W-1:0] COND_NEVER  = 4'd13;

   // Bit order matches the write mask: [0]=CF, [1]=ZF, [2]=SF, [3]=OF.
   typedef struct packed {
      logic of_f;
      logic sf;
      logic zf;
      logic cf;
   } FLAGS_t;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational condition-code evaluation against a flags value.
module flag_branch_unit_cond_eval
   import flag_branch_unit_pkg::*;
(
   input  FLAGS_t            flags,
   input  logic [COND_W-1:0] cond,
   output logic              taken
);

   logic lt;
   assign lt = flags.sf ^ flags.of_f;

   // Decode the condition code; 13..15 all mean never.
   always_comb begin
      taken = 1'b0;
      unique case (cond)
         COND_EQ:     taken = flags.zf;
         COND_NE:     taken = ~flags.zf;
         COND_LT:     taken = lt;
         COND_GE:     taken = ~lt;
         COND_GT:     taken = ~flags.zf & ~lt;
         COND_LE:     taken = flags.zf | lt;
         COND_LTU:    taken = flags.cf;
         COND_GEU:    taken = ~flags.cf;
         COND_NEG:    taken = flags.sf;
         COND_POS:    taken = ~flags.sf;
         COND_OV:     taken = flags.of_f;
         COND_NOV:    taken = ~flags.of_f;
         COND_ALWAYS: taken = 1'b1;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flags register, in-flight flag-writer tracking and branch resolution.
module flag_branch_unit
   import flag_branch_unit_pkg::*;
#(
   parameter int unsigned MAX_PENDING = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              flag_issue,
   output logic              issue_ready,
   input  logic              flag_wr_valid,
   input  FLAGS_t            flag_wr,
   input  logic [3:0]        flag_wr_mask,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [COND_W-1:0] br_cond,
   input  logic [31:0]       br_target,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_taken,
   output logic [31:0]       res_target,
   output FLAGS_t            flags_q
);

   localparam int unsigned PW = $clog2(MAX_PENDING + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [PW-1:0]     pending;
   logic [COND_W-1:0] cond_q;
   logic [31:0]       target_q;
   logic [COND_W-1:0] cond_sel;
   logic              taken;
   logic              issue_ok;
   logic              flags_settled;

   assign br_ready      = (state == IDLE);
   assign issue_ready   = (pending != PW'(MAX_PENDING)) && (state == IDLE);
   assign issue_ok      = flag_issue & issue_ready;
   // No older writer outstanding and nothing landing this cycle: flags_q is final.
   assign flags_settled = (pending == '0) && !flag_wr_valid;
   // In IDLE the incoming request is evaluated directly; otherwise the held one.
   assign cond_sel      = (state == IDLE) ? br_cond : cond_q;

   flag_branch_unit_cond_eval u_cond_eval (
      .flags (flags_q),
      .cond  (cond_sel),
      .taken (taken)
   );

   // Masked field-wise flag writeback; flush leaves the flags intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else if (flag_wr_valid) begin
         flags_q <= FLAGS_t'((flags_q & ~flag_wr_mask) | (flag_wr & flag_wr_mask));
      end
   end

   // In-flight flag writer count, saturating at zero.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pending <= '0;
      end else if (issue_ok && !flag_wr_valid) begin
         pending <= pending + 1'b1;
      end else if (!issue_ok && flag_wr_valid && (pending != '0)) begin
         pending <= pending - 1'b1;
      end
   end

   // Branch hold/evaluate/respond FSM with registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cond_q     <= '0;
         target_q   <= '0;
         res_valid  <= 1'b0;
         res_taken  <= 1'b0;
         res_target <= '0;
      end else if (flush) begin
         state     <= IDLE;
         res_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (br_valid) begin
                  cond_q   <= br_cond;
                  target_q <= br_target;
                  if (flags_settled) begin
                     res_taken  <= taken;
                     res_target <= br_target;
                     res_valid  <= 1'b1;
                     state      <= RESP;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (flags_settled) begin
                  res_taken  <= taken;
                  res_target <= target_q;
                  res_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: directed scenarios then random traffic.
module tb_flag_branch_unit;

   logic        clk = 1'b0;
   logic        rst, flush, flag_issue, flag_wr_valid, br_valid, res_ready;
   logic [3:0]  flag_wr, flag_wr_mask, br_cond;
   logic [31:0] br_target;
   logic        issue_ready, br_ready, res_valid, res_taken;
   logic [31:0] res_target;
   logic [3:0]  flags_q;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   flag_branch_unit #(.MAX_PENDING(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .flag_issue    (flag_issue),
      .issue_ready   (issue_ready),
      .flag_wr_valid (flag_wr_valid),
      .flag_wr       (flag_wr),
      .flag_wr_mask  (flag_wr_mask),
      .br_valid      (br_valid),
      .br_ready      (br_ready),
      .br_cond       (br_cond),
      .br_target     (br_target),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_taken     (res_taken),
      .res_target    (res_target),
      .flags_q       (flags_q)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference condition evaluation straight from the condition table.
   function automatic bit ref_eval(input int c, input bit [3:0] f);
      bit cf, zf, sf, ov, lt;
      cf = f[0]; zf = f[1]; sf = f[2]; ov = f[3];
      lt = (sf != ov);
      case (c)
         0: return zf;
         1: return !zf;
         2: return lt;
         3: return !lt;
         4: return !zf && !lt;
         5: return zf || lt;
         6: return cf;
         7: return !cf;
         8: return sf;
         9: return !sf;
         10: return ov;
         11: return !ov;
         12: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference model: flags, outstanding writer count, a held branch, an offered result.
   bit [3:0]  m_flags = '0;
   int        m_pend = 0;
   bit        m_held = 0;
   bit        m_resout = 0;
   int        m_hc = 0;
   bit [31:0] m_ht = '0;
   bit [32:0] exp_q[$];

   always @(posedge clk) begin
      bit idle, iss_ok, accepted;
      idle   = !m_held && !m_resout;
      iss_ok = flag_issue && (m_pend < 3) && idle;
      if (rst) begin
         m_flags = '0; m_pend = 0; m_held = 0; m_resout = 0;
         exp_q.delete();
      end else begin
         if (flush) begin
            // Offered result dropped without a handshake: discard its expectation.
            if (m_resout && !res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            m_held = 0; m_resout = 0; m_pend = 0;
         end else begin
            accepted = 0;
            if (m_resout && res_ready) m_resout = 0;
            if (idle && br_valid) begin
               m_held = 1; m_hc = int'(br_cond); m_ht = br_target; accepted = 1;
            end
            if (m_held && m_pend == 0 && !flag_wr_valid) begin
               exp_q.push_back({ref_eval(m_hc, m_flags), m_ht});
               m_held = 0; m_resout = 1;
            end
            if (iss_ok && flag_wr_valid) m_pend = m_pend;
            else if (iss_ok) m_pend = m_pend + 1;
            else if (flag_wr_valid && m_pend > 0) m_pend = m_pend - 1;
            if (accepted && m_resout && m_held) m_held = 0;
         end
         if (flag_wr_valid) m_flags = (m_flags & ~flag_wr_mask) | (flag_wr & flag_wr_mask);
      end
   end

   // Handshake and flag state against the model, sampled mid-cycle.
   always @(negedge clk) begin
      chk("br_ready", 32'(br_ready), 32'(!m_held && !m_resout));
      chk("issue_ready", 32'(issue_ready), 32'(!m_held && !m_resout && m_pend < 3));
      chk("res_valid", 32'(res_valid), 32'(m_resout));
      chk("flags_q", 32'(flags_q), 32'(m_flags));
   end

   // Result monitor: compare offered result against scoreboard head, pop on handshake.
   always @(negedge clk) begin
      if (res_valid) begin
         if (exp_q.size() == 0) begin
            chk("res_unexpected", 32'(res_valid), 32'(0));
         end else begin
            chk("res_taken", 32'(res_taken), 32'(exp_q[0][32]));
            chk("res_target", res_target, exp_q[0][31:0]);
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input bit iss, input bit wv, input bit [3:0] wf, input bit [3:0] wm,
                      input bit bv, input bit [3:0] bc, input bit [31:0] bt, input bit rr,
                      input bit fl);
      flag_issue = iss; flag_wr_valid = wv; flag_wr = wf; flag_wr_mask = wm;
      br_valid = bv; br_cond = bc; br_target = bt; res_ready = rr; flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc(input bit rr);
      cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0, rr, 0);
   endtask

   initial begin
      rst = 1'b1;
      idle_cyc(0);
      idle_cyc(0);
      rst = 1'b0;
      // ALWAYS branch with nothing pending, hold one cycle, then consume.
      cyc(0, 0, 4'h0, 4'h0, 1, 4'd12, 32'h100, 0, 0);
      idle_cyc(0);
      idle_cyc(1);
      // Two writers in flight, EQ branch waits for both writebacks.
      cyc(1, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 0);
      cyc(1, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 0);
      cyc(0, 0, 4'h0, 4'h0, 1, 4'd0, 32'h200, 0, 0);
      idle_cyc(0);
      cyc(0, 1, 4'h0, 4'b0010, 0, 4'h0, 32'h0, 0, 0);
      idle_cyc(0);
      cyc(0, 1, 4'b0010, 4'b0010, 0, 4'h0, 32'h0, 0, 0);
      idle_cyc(0);
      idle_cyc(0);
      idle_cyc(1);
      // Fill to the limit, extra issue ignored, one writeback reopens issue.
      for (int i = 0; i < 4; i++) cyc(1, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 0);
      cyc(0, 1, 4'b0010, 4'b0000, 0, 4'h0, 32'h0, 0, 0);
      idle_cyc(0);
      for (int i = 0; i < 2; i++) cyc(0, 1, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 0);
      // CF=1 SF=1 OF=0, then LTU/GEU/LT/GE, then CF-only clear.
      cyc(0, 1, 4'b0101, 4'hF, 0, 4'h0, 32'h0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         bit [3:0] c;
         c = (i == 0) ? 4'd6 : (i == 1) ? 4'd7 : (i == 2) ? 4'd2 : 4'd3;
         cyc(0, 0, 4'h0, 4'h0, 1, c, 32'h300 + 32'(i), 0, 0);
         idle_cyc(1);
      end
      cyc(0, 1, 4'b0000, 4'b0001, 0, 4'h0, 32'h0, 0, 0);
      // Result held under backpressure for five cycles.
      cyc(0, 0, 4'h0, 4'h0, 1, 4'd12, 32'hCAFE_0000, 0, 0);
      for (int i = 0; i < 5; i++) idle_cyc(0);
      idle_cyc(1);
      // Flush while a branch waits on two writers, then a writeback at zero.
      cyc(1, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 0);
      cyc(1, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 0);
      cyc(0, 0, 4'h0, 4'h0, 1, 4'd1, 32'h400, 0, 0);
      idle_cyc(0);
      cyc(0, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 1);
      idle_cyc(0);
      cyc(0, 1, 4'h0, 4'h0, 0, 4'h0, 32'h0, 0, 0);
      cyc(0, 0, 4'h0, 4'h0, 1, 4'd12, 32'h500, 1, 0);
      idle_cyc(1);
      // Random traffic, including flush and reset mid-operation.
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(499) == 0);
         cyc($urandom_range(2) == 0, $urandom_range(2) == 0, 4'($urandom), 4'($urandom),
             $urandom_range(2) == 0, 4'($urandom), $urandom, $urandom_range(1) == 0,
             $urandom_range(59) == 0);
      end
      rst = 1'b0;
      for (int n = 0; n < 10; n++) cyc(0, 1, 4'h0, 4'h0, 0, 4'h0, 32'h0, 1, 0);
      for (int n = 0; n < 4; n++) idle_cyc(1);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
